// File: rtl/c3540_alu.sv
// rtl/c3540_alu.sv - 8-bit registered ALU with BCD, shift, secondary-result and flag outputs
module c3540_alu (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [7:0] C,
   input  logic [7:0] D,
   input  logic [3:0] OP,
   input  logic       N270,
   input  logic       N274,
   input  logic       N283,
   input  logic       N294,
   input  logic       N303,
   input  logic       N311,
   input  logic       N317,
   input  logic       N322,
   input  logic       N326,
   input  logic       N329,
   input  logic       N330,
   input  logic       N343,
   input  logic       N349,
   input  logic       N350,
   output logic [7:0] R,
   output logic [7:0] S,
   output logic       N5120,
   output logic       N5121,
   output logic       N5192,
   output logic       N5231,
   output logic       N5360,
   output logic       N5361
);

   // Reserved pins are deliberately ignored; folding them here keeps them out of all logic.
   logic unused_reserved;
   assign unused_reserved = ^{N330, N343, N349, N350};

   logic [7:0] x, y;
   logic [8:0] sum9, diff9;
   logic [4:0] bcd_lo, bcd_hi, sub_lo;
   logic       bcd_lo_c, bcd_hi_c;
   logic [7:0] t;
   logic       co, v;
   logic [7:0] r_next, s_next;
   logic       z_next, n_next, p_next, eq_next;

   // Operand selection and shared binary/decimal adders.
   always_comb begin
      x        = N303 ? C : A;
      y        = N311 ? D : B;
      sum9     = {1'b0, x} + {1'b0, y} + {8'd0, N270};
      diff9    = {1'b0, x} + {1'b0, ~y} + {8'd0, N270};
      bcd_lo   = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'd0, N270};
      bcd_lo_c = (bcd_lo > 5'd9);
      bcd_hi   = {1'b0, x[7:4]} + {1'b0, y[7:4]} + {4'd0, bcd_lo_c};
      bcd_hi_c = (bcd_hi > 5'd9);
      sub_lo   = {1'b0, x[3:0]} + {1'b0, ~y[3:0]} + {4'd0, N270};
   end

   // Core result T, carry and overflow selected by opcode.
   always_comb begin
      t  = 8'd0;
      co = 1'b0;
      v  = 1'b0;
      case (OP)
         4'd0: begin
            if (N274) begin
               t[3:0] = bcd_lo_c ? (bcd_lo[3:0] + 4'd6) : bcd_lo[3:0];
               t[7:4] = bcd_hi_c ? (bcd_hi[3:0] + 4'd6) : bcd_hi[3:0];
               co     = bcd_hi_c;
            end else begin
               t  = sum9[7:0];
               co = sum9[8];
               v  = (x[7] == y[7]) && (sum9[7] != x[7]);
            end
         end
         4'd1: begin
            if (N274) begin
               t[3:0] = sub_lo[4] ? diff9[3:0] : (diff9[3:0] - 4'd6);
               t[7:4] = diff9[8]  ? diff9[7:4] : (diff9[7:4] - 4'd6);
               co     = diff9[8];
            end else begin
               t  = diff9[7:0];
               co = diff9[8];
               v  = (x[7] != y[7]) && (diff9[7] != x[7]);
            end
         end
         4'd2:  t = x & y;
         4'd3:  t = x | y;
         4'd4:  t = x ^ y;
         4'd5:  t = ~x;
         4'd6:  t = x;
         4'd7:  t = y;
         4'd8: begin
            t  = x + 8'd1;
            co = (x == 8'hFF);
            v  = (x == 8'h7F);
         end
         4'd9: begin
            t  = x - 8'd1;
            co = (x != 8'h00);
            v  = (x == 8'h80);
         end
         4'd10: begin
            t  = {x[6:0], N283};
            co = x[7];
         end
         4'd11: begin
            t  = {N294, x[7:1]};
            co = x[0];
         end
         4'd12: begin
            t  = {x[6:0], x[7]};
            co = x[7];
         end
         4'd13: begin
            t  = {x[0], x[7:1]};
            co = x[0];
         end
         4'd14: t = ~(x & y);
         default: t = ~(x | y);
      endcase
   end

   // Optional inversion, flags from the final result, and the secondary S unit.
   always_comb begin
      r_next  = N329 ? ~t : t;
      z_next  = (r_next == 8'd0);
      n_next  = r_next[7];
      p_next  = ^r_next;
      eq_next = (x == y);
      s_next  = 8'd0;
      case ({N326, N322})
         2'b00: s_next = r_next & C;
         2'b01: s_next = r_next | D;
         2'b10: begin
            for (int i = 0; i < 8; i++) begin
               s_next[i] = r_next[7 - i];
            end
         end
         default: s_next = {r_next[3:0], r_next[7:4]};
      endcase
   end

   // Output registers: reset wins, otherwise load only when update is enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         R     <= 8'd0;
         S     <= 8'd0;
         N5120 <= 1'b0;
         N5121 <= 1'b0;
         N5192 <= 1'b0;
         N5231 <= 1'b0;
         N5360 <= 1'b0;
         N5361 <= 1'b0;
      end else if (N317) begin
         R     <= r_next;
         S     <= s_next;
         N5120 <= co;
         N5121 <= z_next;
         N5192 <= v;
         N5231 <= n_next;
         N5360 <= p_next;
         N5361 <= eq_next;
      end
   end

endmodule

// File: tb/tb_c3540_alu.sv
// tb/tb_c3540_alu.sv - self-checking bench for c3540_alu against a decimal/integer reference model
module tb_c3540_alu;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a, b, c, d;
   logic [3:0] op;
   logic       ci, bcd, fl, fr, xs, ys, en, inv;
   logic [1:0] ss;
   logic [3:0] res;
   logic [7:0] r_o, s_o;
   logic       co_o, z_o, v_o, n_o, p_o, eq_o;

   int errors = 0;
   int checks = 0;
   logic [21:0] exp_q;
   logic [21:0] held;

   always #5 clk = ~clk;

   c3540_alu dut (
      .clk(clk), .rst(rst),
      .A(a), .B(b), .C(c), .D(d), .OP(op),
      .N270(ci), .N274(bcd), .N283(fl), .N294(fr), .N303(xs), .N311(ys),
      .N317(en), .N322(ss[0]), .N326(ss[1]), .N329(inv),
      .N330(res[0]), .N343(res[1]), .N349(res[2]), .N350(res[3]),
      .R(r_o), .S(s_o),
      .N5120(co_o), .N5121(z_o), .N5192(v_o), .N5231(n_o), .N5360(p_o), .N5361(eq_o)
   );

   function automatic logic [21:0] obs();
      return {r_o, s_o, co_o, z_o, v_o, n_o, p_o, eq_o};
   endfunction

   function automatic int to_signed(int u);
      return (u > 127) ? u - 256 : u;
   endfunction

   function automatic int dec(int u);
      return (u / 16) * 10 + (u % 16);
   endfunction

   // Reference: {R, S, CO, Z, V, N, P, EQ} from the current input variables.
   function automatic logic [21:0] model();
      int x, y, t, cy, ov, s, r, sr, par, sv;
      x = xs ? int'(c) : int'(a);
      y = ys ? int'(d) : int'(b);
      t = 0; cy = 0; ov = 0;
      case (op)
         4'd0: if (bcd) begin
                  s = dec(x) + dec(y) + int'(ci);
                  cy = (s >= 100); s = s % 100;
                  t = (s / 10) * 16 + s % 10;
               end else begin
                  s = x + y + int'(ci);
                  t = s % 256; cy = (s > 255);
                  sv = to_signed(x) + to_signed(y) + int'(ci);
                  ov = (sv > 127 || sv < -128);
               end
         4'd1: if (bcd) begin
                  s = dec(x) - dec(y) - (1 - int'(ci));
                  cy = (s >= 0); if (s < 0) s = s + 100;
                  t = (s / 10) * 16 + s % 10;
               end else begin
                  s = x + (255 - y) + int'(ci);
                  t = s % 256; cy = (s > 255);
                  sv = to_signed(x) - to_signed(y) - 1 + int'(ci);
                  ov = (sv > 127 || sv < -128);
               end
         4'd2:  t = x & y;
         4'd3:  t = x | y;
         4'd4:  t = x ^ y;
         4'd5:  t = 255 - x;
         4'd6:  t = x;
         4'd7:  t = y;
         4'd8:  begin t = (x + 1) % 256; cy = (x == 255); ov = (to_signed(x) + 1 > 127); end
         4'd9:  begin t = (x + 255) % 256; cy = (x != 0); ov = (to_signed(x) - 1 < -128); end
         4'd10: begin t = (x * 2) % 256 + int'(fl); cy = x / 128; end
         4'd11: begin t = int'(fr) * 128 + x / 2; cy = x % 2; end
         4'd12: begin t = (x * 2) % 256 + x / 128; cy = x / 128; end
         4'd13: begin t = (x % 2) * 128 + x / 2; cy = x % 2; end
         4'd14: t = 255 - (x & y);
         default: t = 255 - (x | y);
      endcase
      r = inv ? 255 - t : t;
      par = 0;
      for (int i = 0; i < 8; i++) par = par ^ ((r >> i) & 1);
      case (ss)
         2'd0: sr = r & int'(c);
         2'd1: sr = r | int'(d);
         2'd2: begin
                  sr = 0;
                  for (int i = 0; i < 8; i++) sr = sr + (((r >> i) & 1) << (7 - i));
               end
         default: sr = (r % 16) * 16 + r / 16;
      endcase
      return {8'(r), 8'(sr), cy != 0, r == 0, ov != 0, r >= 128, par != 0, x == y};
   endfunction

   task automatic check(input string tag, input logic [21:0] o, input logic [21:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // One clock edge; the expected register state advances with the same rules as the spec.
   task automatic step(input string tag);
      logic [21:0] nxt;
      nxt = model();
      @(posedge clk);
      #1;
      if (rst) exp_q = 22'd0;
      else if (en) exp_q = nxt;
      check(tag, obs(), exp_q);
   endtask

   task automatic defaults();
      rst = 0; a = 0; b = 0; c = 0; d = 0; op = 0; ci = 0; bcd = 0; fl = 0; fr = 0;
      xs = 0; ys = 0; en = 1; inv = 0; ss = 0; res = 0;
   endtask

   initial begin
      defaults();
      exp_q = 22'd0;

      // Reset with arbitrary inputs clears everything.
      a = 8'hA5; b = 8'h5A; c = 8'h3C; d = 8'hC3; op = 4'd3; inv = 1; ss = 2'd1; res = 4'hF;
      rst = 1;
      step("reset");
      check("reset_all_zero", obs(), 22'd0);

      // Signed overflow on binary add.
      defaults();
      a = 8'h7F; b = 8'h01;
      step("add_ovf");
      check("add_ovf_r", {14'd0, r_o}, 22'h80);
      check("add_ovf_flags", {16'd0, co_o, z_o, v_o, n_o, p_o, 1'b0}, 22'b0_0_1_1_1_0);

      // BCD add, then decimal carry out to zero.
      bcd = 1; a = 8'h19; b = 8'h28;
      step("bcd_add1");
      check("bcd_add1_r", {13'd0, co_o, r_o}, {13'd0, 1'b0, 8'h47});
      a = 8'h99; b = 8'h01;
      step("bcd_add2");
      check("bcd_add2_r", {12'd0, z_o, co_o, r_o}, {12'd0, 1'b1, 1'b1, 8'h00});

      // Subtract equal operands, then with inversion.
      defaults();
      op = 4'd1; a = 8'h05; b = 8'h05; ci = 1;
      step("sub_eq");
      check("sub_eq_bits", {11'd0, eq_o, z_o, co_o, r_o}, {11'd0, 1'b1, 1'b1, 1'b1, 8'h00});
      inv = 1;
      step("sub_inv");
      check("sub_inv_bits", {13'd0, z_o, r_o}, {13'd0, 1'b0, 8'hFF});

      // Shift left with fill, S nibble-swapped.
      defaults();
      op = 4'd10; a = 8'h81; fl = 1; ss = 2'b11;
      step("shl");
      check("shl_bits", {5'd0, co_o, s_o, r_o}, {5'd0, 1'b1, 8'h30, 8'h03});

      // Hold: update disabled, inputs wander for three edges.
      held = obs();
      en = 0;
      for (int k = 0; k < 3; k++) begin
         a = 8'($urandom); b = 8'($urandom); op = 4'($urandom); inv = 1'($urandom);
         step("hold");
         check("hold_unchanged", obs(), held);
      end

      // Reset beats a disabled enable and a pending result.
      en = 1; a = 8'h40; b = 8'h40; op = 4'd0;
      step("load_before_rst");
      rst = 1; en = 0;
      step("rst_no_en");
      rst = 1; en = 1;
      step("rst_with_en");
      rst = 0; en = 1; a = 8'h12; b = 8'h34;
      step("first_after_rst");

      // Randomised sweep across every opcode and control.
      for (int k = 0; k < 300; k++) begin
         a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
         op = 4'($urandom); ci = 1'($urandom); bcd = 1'($urandom);
         fl = 1'($urandom); fr = 1'($urandom); xs = 1'($urandom); ys = 1'($urandom);
         inv = 1'($urandom); ss = 2'($urandom); res = 4'($urandom);
         en = ($urandom_range(0, 7) != 0);
         rst = ($urandom_range(0, 19) == 0);
         if (bcd) begin
            a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            c = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         end
         if (k % 10 == 0) ys = xs;
         if (k % 10 == 0) begin b = a; d = c; end
         step("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
